fp_align_mantissas: RTL and testbench

Pipelined alignment stage for the single-precision FP adder. It sits directly downstream of the exponent-compare stage and consumes its absolute exponent difference and larger exponent. It selects the mantissa belonging to the larger exponent, right-shifts the other mantissa by the difference, and keeps guard, round and sticky bits. Results are handed to the mantissa add/subtract stage through a valid/ready handshake.

---
 rtl/fp_align_mantissas.sv | 72 +++++++
 tb/tb_fp_align_mantissas.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_mantissas.sv
// fp_align_mantissas: two-stage select/shift alignment for the single-precision adder
module fp_align_mantissas (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] mant1,
    input  logic [23:0] mant2,
    input  logic        exp1_ge,
    input  logic [7:0]  diff,
    input  logic [7:0]  exp_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] mant_big,
    output logic [26:0] mant_small,
    output logic [7:0]  exp_out,
    output logic        big_is_1
);
    logic        s1_v, s2_v, adv;
    logic [23:0] s1_big, s1_small;
    logic [7:0]  s1_diff, s1_exp;
    logic        s1_b1;
    logic [26:0] ext, sh, lost, shifted;
    assign adv       = !s2_v || out_ready;
    assign in_ready  = !s1_v || adv;
    assign out_valid = s2_v;
    // right shift with guard/round kept and every lost bit folded into sticky
    always_comb begin
        ext     = {s1_small, 3'b000};
        sh      = ext >> s1_diff[4:0];
        lost    = ext & ~({27{1'b1}} << s1_diff[4:0]);
        shifted = (s1_diff >= 8'd27) ? {26'b0, |s1_small} : {sh[26:1], sh[0] | (|lost)};
    end
    // stage 1: pick the larger-exponent mantissa and capture the operand set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v     <= 1'b0;
            s1_big   <= '0;
            s1_small <= '0;
            s1_diff  <= '0;
            s1_exp   <= '0;
            s1_b1    <= 1'b0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_big   <= exp1_ge ? mant1 : mant2;
                s1_small <= exp1_ge ? mant2 : mant1;
                s1_diff  <= diff;
                s1_exp   <= exp_r;
                s1_b1    <= exp1_ge;
            end
        end
    end
    // stage 2: output register, held while downstream stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_v       <= 1'b0;
            mant_big   <= '0;
            mant_small <= '0;
            exp_out    <= '0;
            big_is_1   <= 1'b0;
        end else if (adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                mant_big   <= s1_big;
                mant_small <= shifted;
                exp_out    <= s1_exp;
                big_is_1   <= s1_b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_align_mantissas.sv
// tb_fp_align_mantissas: directed checks of select, shift, sticky, backpressure and reset
module tb_fp_align_mantissas;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] mant1 = '0, mant2 = '0;
    logic        exp1_ge = 1'b0;
    logic [7:0]  diff = '0, exp_r = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] mant_big;
    logic [26:0] mant_small;
    logic [7:0]  exp_out;
    logic        big_is_1;
    int total = 0;
    int bad = 0;

    fp_align_mantissas dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .mant1(mant1), .mant2(mant2), .exp1_ge(exp1_ge), .diff(diff), .exp_r(exp_r),
        .out_valid(out_valid), .out_ready(out_ready), .mant_big(mant_big),
        .mant_small(mant_small), .exp_out(exp_out), .big_is_1(big_is_1)
    );

    always #5 clk = ~clk;

    // drives one set into an empty pipe and captures what emerges
    task automatic apply(input logic [23:0] m1, input logic [23:0] m2, input logic ge,
                         input logic [7:0] d, input logic [7:0] e,
                         output logic v_early, output logic v, output logic [23:0] mb,
                         output logic [26:0] ms, output logic [7:0] eo, output logic b1);
        @(negedge clk);
        mant1 = m1; mant2 = m2; exp1_ge = ge; diff = d; exp_r = e;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        v_early = out_valid;
        @(negedge clk);
        v = out_valid; mb = mant_big; ms = mant_small; eo = exp_out; b1 = big_is_1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ctl: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        total++;
        if (mant_big !== 24'h0 || mant_small !== 27'h0 || exp_out !== 8'h0 || big_is_1 !== 1'b0) begin
            bad++; $display("FAIL reset_data: %h %h %h %b want zeros", mant_big, mant_small, exp_out, big_is_1);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_equal();
        logic ve, v, b1; logic [23:0] mb; logic [26:0] ms; logic [7:0] eo;
        apply(24'h800000, 24'h800000, 1'b1, 8'd0, 8'h7F, ve, v, mb, ms, eo, b1);
        total++;
        if (ve !== 1'b0 || v !== 1'b1) begin
            bad++; $display("FAIL equal_latency: early=%b late=%b want 0 1", ve, v);
        end
        total++;
        if (mb !== 24'h800000 || ms !== 27'h4000000 || eo !== 8'h7F || b1 !== 1'b1) begin
            bad++; $display("FAIL equal: %h %h %h %b want 800000 4000000 7f 1", mb, ms, eo, b1);
        end
    endtask

    task automatic test_op2_larger();
        logic ve, v, b1; logic [23:0] mb; logic [26:0] ms; logic [7:0] eo;
        apply(24'h800000, 24'hA00000, 1'b0, 8'd1, 8'h80, ve, v, mb, ms, eo, b1);
        total++;
        if (v !== 1'b1 || mb !== 24'hA00000 || ms !== 27'h2000000 || eo !== 8'h80 || b1 !== 1'b0) begin
            bad++; $display("FAIL op2_larger: v=%b %h %h %h %b want 1 a00000 2000000 80 0", v, mb, ms, eo, b1);
        end
    endtask

    task automatic test_sticky();
        logic ve, v, b1; logic [23:0] mb; logic [26:0] ms; logic [7:0] eo;
        apply(24'hFFFFFF, 24'hC00001, 1'b1, 8'd3, 8'h90, ve, v, mb, ms, eo, b1);
        total++;
        if (ms !== 27'h0C00001 || mb !== 24'hFFFFFF || b1 !== 1'b1) begin
            bad++; $display("FAIL sticky_d3: %h %h %b want 0c00001 ffffff 1", ms, mb, b1);
        end
        apply(24'hFFFFFF, 24'hC00001, 1'b1, 8'd26, 8'h90, ve, v, mb, ms, eo, b1);
        total++;
        if (ms !== 27'h0000001) begin
            bad++; $display("FAIL sticky_d26: %h want 0000001", ms);
        end
        apply(24'hFFFFFF, 24'h800000, 1'b1, 8'd24, 8'h90, ve, v, mb, ms, eo, b1);
        total++;
        if (ms !== 27'h0000004) begin
            bad++; $display("FAIL guard_d24: %h want 0000004", ms);
        end
        apply(24'hFFFFFF, 24'h800001, 1'b1, 8'd4, 8'h90, ve, v, mb, ms, eo, b1);
        total++;
        if (ms !== 27'h0400001) begin
            bad++; $display("FAIL sticky_d4: %h want 0400001", ms);
        end
    endtask

    task automatic test_large_shift();
        logic ve, v, b1; logic [23:0] mb; logic [26:0] ms; logic [7:0] eo;
        apply(24'h000001, 24'hFFFFFF, 1'b0, 8'd30, 8'hA0, ve, v, mb, ms, eo, b1);
        total++;
        if (ms !== 27'h0000001 || mb !== 24'hFFFFFF) begin
            bad++; $display("FAIL large_one: %h %h want 0000001 ffffff", ms, mb);
        end
        apply(24'h000000, 24'hFFFFFF, 1'b0, 8'd30, 8'hA0, ve, v, mb, ms, eo, b1);
        total++;
        if (ms !== 27'h0) begin
            bad++; $display("FAIL large_zero: %h want 0", ms);
        end
        apply(24'hFFFFFF, 24'h800000, 1'b1, 8'd255, 8'hA0, ve, v, mb, ms, eo, b1);
        total++;
        if (ms !== 27'h0000001) begin
            bad++; $display("FAIL large_255: %h want 0000001", ms);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp_mb [4] = '{24'h800000, 24'h800001, 24'h800002, 24'h800003};
        logic [26:0] exp_ms [4] = '{27'h2000000, 27'h1000000, 27'h0800000, 27'h0400000};
        int sent = 0, got = 0, last = -1, gap_bad = 0, hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid = (sent < 4);
            mant1 = 24'h800000 | 24'(sent); mant2 = 24'h800000; exp1_ge = 1'b1;
            diff = 8'(sent + 1); exp_r = 8'(8'h10 + sent);
            #1;
            if (c >= 2 && c < 5 && (out_valid !== 1'b1 || mant_big !== 24'h800000 || mant_small !== 27'h2000000))
                hold_bad++;
            if (c == 4) begin
                total++;
                if (sent !== 2 || in_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_stall: accepted=%0d in_ready=%b want 2 0", sent, in_ready);
                end
            end
            if (out_valid && out_ready && got < 4) begin
                total++;
                if (mant_big !== exp_mb[got] || mant_small !== exp_ms[got] || exp_out !== 8'(8'h10 + got)) begin
                    bad++; $display("FAIL bp_order%0d: %h %h %h want %h %h %h", got, mant_big, mant_small,
                                    exp_out, exp_mb[got], exp_ms[got], 8'(8'h10 + got));
                end
                if (last >= 0 && c != last + 1) gap_bad++;
                last = c;
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        total++;
        if (hold_bad != 0) begin
            bad++; $display("FAIL bp_hold: unstable cycles=%0d want 0", hold_bad);
        end
        total++;
        if (got != 4 || gap_bad != 0) begin
            bad++; $display("FAIL bp_drain: got=%0d gaps=%0d want 4 0", got, gap_bad);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, stall = 0, order_bad = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_valid = (sent < 6);
            mant1 = 24'h900000 + 24'(sent); mant2 = 24'h800000; exp1_ge = 1'b1;
            diff = 8'd0; exp_r = 8'h40;
            #1;
            if (in_valid && !in_ready) stall++;
            if (out_valid) begin
                if (mant_big !== 24'h900000 + 24'(got) || mant_small !== 27'h4000000) order_bad++;
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        total++;
        if (stall != 0 || got != 6 || order_bad != 0) begin
            bad++; $display("FAIL b2b: stalls=%0d got=%0d order_errs=%0d want 0 6 0", stall, got, order_bad);
        end
    endtask

    task automatic test_reset_midflight();
        logic ve, v, b1; logic [23:0] mb; logic [26:0] ms; logic [7:0] eo;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        mant1 = 24'hABCDEF; mant2 = 24'h123456; exp1_ge = 1'b1; diff = 8'd2; exp_r = 8'h55;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mant_big !== 24'h0 || mant_small !== 27'h0) begin
            bad++; $display("FAIL rst_mid: out_valid=%b in_ready=%b mb=%h ms=%h want 0 1 0 0",
                            out_valid, in_ready, mant_big, mant_small);
        end
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_stale: out_valid=%b want 0", out_valid);
        end
        apply(24'h400000, 24'hC00000, 1'b0, 8'd5, 8'h22, ve, v, mb, ms, eo, b1);
        total++;
        if (ve !== 1'b0 || v !== 1'b1 || mb !== 24'hC00000 || ms !== 27'h0100000 || eo !== 8'h22 || b1 !== 1'b0) begin
            bad++; $display("FAIL rst_after: %b %b %h %h %h %b want 0 1 c00000 0100000 22 0", ve, v, mb, ms, eo, b1);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_op2_larger();
        test_sticky();
        test_large_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
